// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and fixed-latency sequencer for the shared memory port
// used by the instruction-fetch and data load/store requesters.
module mem_port_arbiter #(
    parameter int N   = 32,
    parameter int LAT = 2
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         if_req_in,
    input  logic [N-1:0] if_addr_in,
    output logic         if_gnt_out,
    output logic         if_valid_out,
    output logic [N-1:0] if_rdata_out,
    input  logic         d_req_in,
    input  logic         d_we_in,
    input  logic [N-1:0] d_addr_in,
    input  logic [N-1:0] d_wdata_in,
    output logic         d_gnt_out,
    output logic         d_valid_out,
    output logic [N-1:0] d_rdata_out,
    output logic         mem_sel_out,
    output logic         mem_en_out,
    output logic         mem_we_out,
    output logic [N-1:0] mem_addr_out,
    output logic [N-1:0] mem_wdata_out,
    input  logic [N-1:0] mem_rdata_in,
    output logic         busy_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    state_t       state_q, state_d;
    logic         owner_q, owner_d;
    logic         last_owner_q, last_owner_d;
    logic [3:0]   lat_cnt_q, lat_cnt_d;
    logic [N-1:0] addr_q, addr_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic         we_q, we_d;
    logic [N-1:0] if_rdata_q, if_rdata_d;
    logic [N-1:0] d_rdata_q, d_rdata_d;
    logic         mem_en_q, mem_en_d;
    logic         mem_we_q, mem_we_d;
    logic         if_valid_q, if_valid_d;
    logic         d_valid_q, d_valid_d;
    logic         busy_q, busy_d;

    logic idle;
    logic win_d;
    logic if_gnt;
    logic d_gnt;

    // On a tie the requester that did not own the port last time wins.
    assign idle   = (state_q == IDLE);
    assign win_d  = d_req_in && (!if_req_in || !last_owner_q);
    assign d_gnt  = rst_n_in && idle && win_d;
    assign if_gnt = rst_n_in && idle && if_req_in && !win_d;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        lat_cnt_d    = lat_cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        if_valid_d   = 1'b0;
        d_valid_d    = 1'b0;
        busy_d       = busy_q;
        case (state_q)
            IDLE: begin
                if (if_gnt || d_gnt) begin
                    owner_d      = d_gnt;
                    last_owner_d = d_gnt;
                    addr_d       = d_gnt ? d_addr_in : if_addr_in;
                    wdata_d      = d_gnt ? d_wdata_in : '0;
                    we_d         = d_gnt && d_we_in;
                    mem_we_d     = d_gnt && d_we_in;
                    mem_en_d     = 1'b1;
                    lat_cnt_d    = LAT_M1;
                    busy_d       = 1'b1;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (lat_cnt_q == 4'd0) begin
                    // Stores leave the requester's read-data register untouched.
                    if (!we_q) begin
                        if (owner_q) begin
                            d_rdata_d = mem_rdata_in;
                        end else begin
                            if_rdata_d = mem_rdata_in;
                        end
                    end
                    mem_en_d   = 1'b0;
                    mem_we_d   = 1'b0;
                    if_valid_d = !owner_q;
                    d_valid_d  = owner_q;
                    state_d    = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            RESP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            lat_cnt_q    <= 4'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            if_valid_q   <= 1'b0;
            d_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            lat_cnt_q    <= lat_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            if_valid_q   <= if_valid_d;
            d_valid_q    <= d_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign if_gnt_out    = if_gnt;
    assign d_gnt_out     = d_gnt;
    assign if_valid_out  = if_valid_q;
    assign if_rdata_out  = if_rdata_q;
    assign d_valid_out   = d_valid_q;
    assign d_rdata_out   = d_rdata_q;
    assign mem_sel_out   = owner_q;
    assign mem_en_out    = mem_en_q;
    assign mem_we_out    = mem_we_q;
    assign mem_addr_out  = addr_q;
    assign mem_wdata_out = wdata_q;
    assign busy_out      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a LAT=2 instance driven through
// directed scenarios plus a LAT=1 instance for the single-cycle access case.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        is_d;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_word;
    logic        if_gnt, if_valid, d_gnt, d_valid;
    logic [31:0] if_rdata, d_rdata;
    logic        mem_sel, mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata;

    logic        rst2_n;
    logic        d_req2;
    logic [31:0] d_addr2, mem_word2;
    logic        if_gnt2, if_valid2, d_gnt2, d_valid2;
    logic [31:0] if_rdata2, d_rdata2;
    logic        mem_sel2, mem_en2, mem_we2, busy2;
    logic [31:0] mem_addr2, mem_wdata2;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    mem_port_arbiter #(.N(32), .LAT(2)) dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .if_req_in(if_req), .if_addr_in(if_addr), .if_gnt_out(if_gnt),
        .if_valid_out(if_valid), .if_rdata_out(if_rdata),
        .d_req_in(d_req), .d_we_in(d_we), .d_addr_in(d_addr), .d_wdata_in(d_wdata),
        .d_gnt_out(d_gnt), .d_valid_out(d_valid), .d_rdata_out(d_rdata),
        .mem_sel_out(mem_sel), .mem_en_out(mem_en), .mem_we_out(mem_we),
        .mem_addr_out(mem_addr), .mem_wdata_out(mem_wdata),
        .mem_rdata_in(mem_word), .busy_out(busy)
    );

    mem_port_arbiter #(.N(32), .LAT(1)) dut_lat1 (
        .clk_in(clk), .rst_n_in(rst2_n),
        .if_req_in(1'b0), .if_addr_in(32'h0), .if_gnt_out(if_gnt2),
        .if_valid_out(if_valid2), .if_rdata_out(if_rdata2),
        .d_req_in(d_req2), .d_we_in(1'b0), .d_addr_in(d_addr2), .d_wdata_in(32'h0),
        .d_gnt_out(d_gnt2), .d_valid_out(d_valid2), .d_rdata_out(d_rdata2),
        .mem_sel_out(mem_sel2), .mem_en_out(mem_en2), .mem_we_out(mem_we2),
        .mem_addr_out(mem_addr2), .mem_wdata_out(mem_wdata2),
        .mem_rdata_in(mem_word2), .busy_out(busy2)
    );

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid pulse of the LAT=2 instance must match the oldest expectation.
    always @(negedge clk) begin
        if (if_valid || d_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: actual if_valid=%0b d_valid=%0b required none",
                         if_valid, d_valid);
            end else begin
                mon_e = sb_q.pop_front();
                check_output("valid_owner", {30'b0, if_valid, d_valid},
                             {30'b0, !mon_e.is_d, mon_e.is_d});
                check_output("valid_rdata", mon_e.is_d ? d_rdata : if_rdata, mon_e.rdata);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_word = 32'h0;
        d_req2 = 1'b0; d_addr2 = 32'h0; mem_word2 = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check_output("rst_if_gnt", {31'b0, if_gnt}, 32'h0);
        check_output("rst_d_gnt", {31'b0, d_gnt}, 32'h0);
        check_output("rst_busy", {31'b0, busy}, 32'h0);
        check_output("rst_mem_en", {31'b0, mem_en}, 32'h0);
        check_output("rst_mem_sel", {31'b0, mem_sel}, 32'h0);
        check_output("rst_mem_addr", mem_addr, 32'h0);
        check_output("rst_if_rdata", if_rdata, 32'h0);
        check_output("rst_d_rdata", d_rdata, 32'h0);
        next_cycle();
        rst_n = 1'b1; if_req = 1'b0; d_req = 1'b0;

        // Tie after reset: fetch, data, fetch
        for (int c = 0; c < 13; c++) begin
            next_cycle();
            if_req = (c <= 8); d_req = (c <= 8); d_we = 1'b0;
            if_addr = 32'h80; d_addr = 32'h200;
            mem_word = (c < 4) ? 32'h1111_1111 : (c < 8) ? 32'h2222_2222 : 32'h3333_3333;
            if (c == 0) sb_q.push_back('{1'b0, 32'h1111_1111});
            if (c == 4) sb_q.push_back('{1'b1, 32'h2222_2222});
            if (c == 8) sb_q.push_back('{1'b0, 32'h3333_3333});
            @(negedge clk);
            check_output($sformatf("tie_if_gnt_c%0d", c), {31'b0, if_gnt}, {31'b0, (c == 0 || c == 8)});
            check_output($sformatf("tie_d_gnt_c%0d", c), {31'b0, d_gnt}, {31'b0, (c == 4)});
            check_output($sformatf("tie_sel_c%0d", c), {31'b0, mem_sel}, {31'b0, (c >= 5 && c <= 8)});
            if (c == 1 || c == 5 || c == 9)
                check_output($sformatf("tie_addr_c%0d", c), mem_addr, (c == 5) ? 32'h200 : 32'h80);
        end

        // Fetch read
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            if_req = (c == 0); d_req = 1'b0; if_addr = 32'h40;
            mem_word = (c == 2) ? 32'h0010_0093 : (c == 1) ? 32'hBAD0_BAD0 : 32'h0;
            if (c == 0) sb_q.push_back('{1'b0, 32'h0010_0093});
            @(negedge clk);
            if (c == 0) check_output("fetch_gnt", {31'b0, if_gnt}, 32'h1);
            check_output($sformatf("fetch_en_c%0d", c), {31'b0, mem_en}, {31'b0, (c == 1 || c == 2)});
            check_output($sformatf("fetch_busy_c%0d", c), {31'b0, busy}, {31'b0, (c >= 1 && c <= 3)});
            check_output($sformatf("fetch_valid_c%0d", c), {31'b0, if_valid}, {31'b0, (c == 3)});
            if (c == 1) begin
                check_output("fetch_addr", mem_addr, 32'h40);
                check_output("fetch_sel", {31'b0, mem_sel}, 32'h0);
            end
            if (c == 4) check_output("fetch_rdata_hold", if_rdata, 32'h0010_0093);
        end

        // Store
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            d_req = (c == 0); d_we = (c == 0); d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
            mem_word = 32'hFFFF_0000;
            if (c == 0) sb_q.push_back('{1'b1, 32'h2222_2222});
            @(negedge clk);
            if (c == 0) check_output("store_gnt", {31'b0, d_gnt}, 32'h1);
            check_output($sformatf("store_we_c%0d", c), {31'b0, mem_we}, {31'b0, (c == 1 || c == 2)});
            check_output($sformatf("store_dvalid_c%0d", c), {31'b0, d_valid}, {31'b0, (c == 3)});
            if (c == 1) begin
                check_output("store_wdata", mem_wdata, 32'hDEAD_BEEF);
                check_output("store_addr", mem_addr, 32'h100);
                check_output("store_sel", {31'b0, mem_sel}, 32'h1);
            end
            if (c == 4) check_output("store_rdata_kept", d_rdata, 32'h2222_2222);
        end

        // Data request arriving while a fetch is busy
        for (int c = 0; c < 9; c++) begin
            next_cycle();
            if_req = (c == 0); if_addr = 32'h44;
            d_req = (c >= 1 && c <= 4); d_we = 1'b0; d_addr = 32'h300;
            mem_word = (c <= 3) ? 32'h0A0A_0A0A : 32'h0B0B_0B0B;
            if (c == 0) sb_q.push_back('{1'b0, 32'h0A0A_0A0A});
            if (c == 4) sb_q.push_back('{1'b1, 32'h0B0B_0B0B});
            @(negedge clk);
            check_output($sformatf("busy_if_gnt_c%0d", c), {31'b0, if_gnt}, {31'b0, (c == 0)});
            check_output($sformatf("busy_d_gnt_c%0d", c), {31'b0, d_gnt}, {31'b0, (c == 4)});
            if (c == 5) check_output("busy_d_addr", mem_addr, 32'h300);
            if (c == 8) check_output("busy_d_rdata", d_rdata, 32'h0B0B_0B0B);
        end

        // Reset in the middle of a data load
        next_cycle();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; mem_word = 32'h5555_5555;
        @(negedge clk);
        check_output("abort_gnt", {31'b0, d_gnt}, 32'h1);
        next_cycle();
        d_req = 1'b0;
        #1;
        check_output("abort_en_before", {31'b0, mem_en}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_output("abort_busy", {31'b0, busy}, 32'h0);
        check_output("abort_en", {31'b0, mem_en}, 32'h0);
        check_output("abort_sel", {31'b0, mem_sel}, 32'h0);
        check_output("abort_addr", mem_addr, 32'h0);
        check_output("abort_d_rdata", d_rdata, 32'h0);
        check_output("abort_if_rdata", if_rdata, 32'h0);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            if_req = 1'b1; d_req = 1'b1;
            @(negedge clk);
            check_output($sformatf("abort_hold_gnt_c%0d", c), {30'b0, if_gnt, d_gnt}, 32'h0);
            check_output($sformatf("abort_hold_dvalid_c%0d", c), {31'b0, d_valid}, 32'h0);
        end
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            if (c == 0) rst_n = 1'b1;
            if_req = (c == 0); d_req = (c == 0); if_addr = 32'h500; mem_word = 32'h7777_7777;
            if (c == 0) sb_q.push_back('{1'b0, 32'h7777_7777});
            @(negedge clk);
            if (c == 0) begin
                check_output("post_rst_if_gnt", {31'b0, if_gnt}, 32'h1);
                check_output("post_rst_d_gnt", {31'b0, d_gnt}, 32'h0);
            end
            check_output($sformatf("post_rst_dvalid_c%0d", c), {31'b0, d_valid}, 32'h0);
        end

        // LAT=1 instance: single load
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            if (c == 0) rst2_n = 1'b1;
            d_req2 = (c == 0); d_addr2 = 32'h600;
            mem_word2 = (c == 1) ? 32'h9999_9999 : 32'h1357_9BDF;
            @(negedge clk);
            if (c == 0) check_output("lat1_gnt", {31'b0, d_gnt2}, 32'h1);
            check_output($sformatf("lat1_en_c%0d", c), {31'b0, mem_en2}, {31'b0, (c == 1)});
            check_output($sformatf("lat1_valid_c%0d", c), {31'b0, d_valid2}, {31'b0, (c == 2)});
            if (c == 2) check_output("lat1_rdata", d_rdata2, 32'h9999_9999);
            if (c == 3) check_output("lat1_busy", {31'b0, busy2}, 32'h0);
        end

        repeat (2) @(negedge clk);
        check_output("scoreboard_drained", sb_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single shared memory port of the RV32I core. It arbitrates between the instruction-fetch requester and the data load/store requester and registers the winner's address, write data and write enable. It drives the select of the 2:1 address/data port mux, runs a fixed-latency access and returns read data with a one-cycle valid pulse.

## Interface
- N, 32, address/data width
- LAT, 2, memory access latency in cycles; legal range 1..15
- clk_in  input  1  clock, rising edge
- rst_n_in  input  1  reset, asynchronous, active-low
- if_req_in  input  1  fetch request; held until if_gnt_out
- if_addr_in  input  N  fetch address
- if_gnt_out  output  1  fetch granted (combinational, IDLE only)
- if_valid_out  output  1  one-cycle pulse: fetch complete, if_rdata_out valid
- if_rdata_out  output  N  fetched word
- d_req_in  input  1  data request; held until d_gnt_out
- d_we_in  input  1  1 = store, 0 = load
- d_addr_in  input  N  data address
- d_wdata_in  input  N  store data
- d_gnt_out  output  1  data granted (combinational, IDLE only)
- d_valid_out  output  1  one-cycle pulse: data access complete
- d_rdata_out  output  N  load result
- mem_sel_out  output  1  port mux select; 1 = data requester, 0 = fetch
- mem_en_out  output  1  memory access enable
- mem_we_out  output  1  memory write enable
- mem_addr_out  output  N  registered access address
- mem_wdata_out  output  N  registered write data
- mem_rdata_in  input  N  memory read data
- busy_out  output  1  state != IDLE

## Operation
- States: IDLE, ACCESS, RESP. Registers: state, owner (0 = IF, 1 = data), last_owner, lat_cnt (4 bits), addr, wdata, we, if_rdata, d_rdata.
- IDLE behaviour:
  - If exactly one req is high, that requester wins.
  - If both are high, the requester opposite last_owner wins (round robin).
  - The winner's gnt is high in that cycle, and the loser's gnt stays low.
  - On the clock edge: owner and last_owner take the winner; addr and wdata are latched from the winner; we = d_we_in if the winner is data, else 0; lat_cnt = LAT-1; state goes to ACCESS.
- ACCESS behaviour:
  - mem_en_out = 1 and mem_we_out = we.
  - lat_cnt decrements each cycle.
  - When lat_cnt == 0, mem_rdata_in is captured into the owner's rdata register, unless we = 1, in which case rdata is unchanged. State then goes to RESP.
- RESP behaviour: the owner's valid_out = 1 for exactly one cycle, then state goes to IDLE. Stores also pulse valid as a completion ack.
- mem_sel_out = owner. It changes only at a grant edge and holds its value through IDLE.
- mem_addr_out, mem_wdata_out and mem_we_out come from registers. mem_we_out is forced to 0 outside ACCESS.
- Requests arriving in ACCESS or RESP are not granted. They are evaluated at the next IDLE cycle.
- A req may drop after gnt without affecting the access in flight.
- Reset (async, any state):
  - state = IDLE, owner = 0, last_owner = 1 (so fetch wins the first tie).
  - All outputs are 0; all data registers are 0.
  - An access in flight is abandoned and no valid is issued.

## Timing
- With a req in IDLE at cycle 0: gnt in cycle 0; mem_en_out in cycles 1..LAT; rdata sampled at the edge ending cycle LAT; valid and rdata_out in cycle LAT+1; IDLE in cycle LAT+2.
- The earliest next grant is in cycle LAT+2, so throughput is one access per LAT+2 cycles.
- rdata_out holds its value after the valid pulse until the next load completes for the same requester.
- gnt depends combinationally on req and state. All other outputs are registered.

## Test plan
- Fetch read, LAT=2:
  - Stimulus: if_req at cycle 0 with addr 0x0000_0040, mem_rdata_in 0x0010_0093 in cycle 2.
  - Required: if_gnt in cycle 0; mem_en in cycles 1-2, mem_addr 0x40, mem_sel 0; if_valid in cycle 3 with if_rdata 0x0010_0093; busy low in cycle 4.
- Tie after reset:
  - Stimulus: both reqs held high.
  - Required: fetch is granted first (cycle 0), data next (cycle 4), then fetch at cycle 8. Grants strictly alternate and mem_sel toggles 0/1/0.
- Store:
  - Stimulus: d_req, d_we=1, addr 0x100, wdata 0xDEAD_BEEF.
  - Required: mem_we = 1 only during the 2 ACCESS cycles, mem_wdata 0xDEAD_BEEF, mem_sel 1; d_valid in cycle 3; d_rdata unchanged.
- Reset mid-access:
  - Stimulus: rst_n low in cycle 1 of a data load.
  - Required: outputs go to 0 immediately, with no d_valid. After release, a tie grants fetch first.
- Request during busy:
  - Stimulus: d_req asserted in cycle 1 while a fetch is in ACCESS.
  - Required: no d_gnt until cycle 4; d_gnt in cycle 4.
- LAT=1 build:
  - Stimulus: a single load.
  - Required: gnt in cycle 0, mem_en in cycle 1 only, valid in cycle 2.
